// File: rtl/frame_writer.sv
// Purpose  : packs a 24-bit RGB pixel stream eight-per-256-bit word and writes each word to frame memory.
// Latency  : mem_valid_data rises at the edge that accepts pixel 7 of a word; a transfer completes in one cycle at the earliest.
// Backpress: with one word waiting on memory, seven more pixels are buffered, then pixel_ready drops until that word completes.
//
// Ports:
//   clk, rst          - single clock; rst is synchronous, active-low
//   pixel_in/_valid/_sof/_ready
//                     - pixel stream in; sof marks pixel 0 of a frame
//   data_wr, mem_data_addr, mem_rw_data, mem_valid_data, mem_ready_data
//                     - memory write port; valid/ready handshake
//   last_addr_update  - one-cycle pulse after the final word of a frame has been written
//
// Word format: pixel k sits in data bits [32k+23:32k]; bits [32k+31:32k+24] are zero.
// This format and the address stepping match the display read path.

module frame_writer #(
    parameter logic [27:0] BASE_ADDR   = 28'h0000000,
    parameter logic [27:0] ADDR_STEP   = 28'd8,
    parameter int          FRAME_WORDS = 38400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  pixel_in,
    input  logic         pixel_valid,
    input  logic         pixel_sof,
    output logic         pixel_ready,
    output logic [255:0] data_wr,
    output logic [27:0]  mem_data_addr,
    output logic         mem_rw_data,
    output logic         mem_valid_data,
    input  logic         mem_ready_data,
    output logic         last_addr_update
);

    localparam int               IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    // Memory-side FSM. REQ doubles as the "output register full" flag.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]       r_state;
    logic             r_run;          // low during reset and for the first edge after release
    logic [2:0]       r_cnt;          // number of pixels held in the packing register
    logic [23:0]      r_pix [0:6];    // pixels 0..6; pixel 7 goes straight from pixel_in into the word
    logic [255:0]     r_out_dat;
    logic [27:0]      r_out_addr;
    logic             r_out_last;     // word in the output register is the last one of the frame
    logic [27:0]      r_addr;         // address the next packed word will be written to
    logic [IDX_W-1:0] r_idx;          // index of the next packed word within the frame
    logic             r_last_pulse;

    logic             w_out_vld;
    logic             w_acc;
    logic [2:0]       w_slot;
    logic             w_load;
    logic             w_done;
    logic             w_idx_wrap;
    logic [255:0]     w_word;

    assign w_out_vld  = (r_state == S_REQ);

    // Both terms come from registers, so there is no path from mem_ready_data to pixel_ready.
    assign pixel_ready = r_run && ((r_cnt != 3'd7) || !w_out_vld);

    assign w_acc      = pixel_valid && pixel_ready;
    // A start-of-frame pixel always lands in slot 0, discarding any partial word.
    assign w_slot     = pixel_sof ? 3'd0 : r_cnt;
    assign w_load     = w_acc && !pixel_sof && (r_cnt == 3'd7);
    assign w_done     = w_out_vld && mem_ready_data;
    assign w_idx_wrap = (r_idx == LAST_IDX);

    always_comb begin
        w_word = '0;
        for (int k = 0; k < 7; k++) begin
            w_word[32*k +: 24] = r_pix[k];
        end
        w_word[247:224] = pixel_in;
    end

    // Packing storage carries no reset: a slot is always written before it is used.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 7; k++) begin
            if (w_acc && (w_slot == 3'(k))) begin
                r_pix[k] <= pixel_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_run        <= 1'b0;
            r_cnt        <= 3'd0;
            r_out_dat    <= '0;
            r_out_addr   <= BASE_ADDR;
            r_out_last   <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_idx        <= '0;
            r_last_pulse <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (w_acc) begin
                r_cnt <= pixel_sof ? 3'd1 : r_cnt + 3'd1;
            end

            // The address restarts on sof. A word already waiting in the output
            // register keeps the address it latched at load.
            if (w_acc && pixel_sof) begin
                r_addr <= BASE_ADDR;
                r_idx  <= '0;
            end else if (w_load) begin
                if (w_idx_wrap) begin
                    r_addr <= BASE_ADDR;
                    r_idx  <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_STEP;
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end

            if (w_load) begin
                r_out_dat  <= w_word;
                r_out_addr <= r_addr;
                r_out_last <= w_idx_wrap;
            end

            // A load can only happen while the output register is empty, because
            // pixel_ready gates the eighth pixel. The REQ branch still stays put
            // if a load coincides with completion.
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready_data && !w_load) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_last_pulse <= w_done && r_out_last;
        end
    end

    assign data_wr          = r_out_dat;
    assign mem_data_addr    = r_out_addr;
    assign mem_rw_data      = 1'b0;
    assign mem_valid_data   = w_out_vld;
    assign last_addr_update = r_last_pulse;

endmodule
